// File: rtl/relock_status_mc_pkg.sv
// Shared lock-state encoding; the single-channel LED decoder uses the same values.
package relock_pkg;
  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    LOCKED       = 2'b00,
    UNLOCKED     = 2'b01,
    RECENT_SHORT = 2'b10,
    RECENT_LONG  = 2'b11
  } relock_state_e;
endpackage

// File: rtl/relock_status_ch.sv
// One lock channel: relock state machine, hold-window counter and saturating unlock-event count.
module relock_status_ch
  import relock_pkg::*;
#(
  parameter longint unsigned HOLD_SHORT = 64'd500_000_000,
  parameter longint unsigned HOLD_LONG  = 64'd6_000_000_000,
  parameter int              CNT_W      = 33,
  parameter int              EVT_W      = 16
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              relock_on,
  input  logic              clr_events,
  output relock_state_e     state,
  output logic [EVT_W-1:0]  evt_cnt
);

  localparam bit               LONG_EN    = (HOLD_LONG != 64'd0);
  localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(HOLD_SHORT - 64'd1);
  localparam logic [CNT_W-1:0] LONG_LAST  = LONG_EN ? CNT_W'(HOLD_LONG - 64'd1) : '0;
  localparam logic [EVT_W-1:0] EVT_MAX    = '1;

  relock_state_e    state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [EVT_W-1:0] evt_reg;
  logic             unlock_evt;

  // Only a fresh entry into UNLOCKED counts; staying there does not.
  assign unlock_evt = relock_on && (state_reg != UNLOCKED);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_reg <= UNLOCKED;
      cnt_reg   <= '0;
      evt_reg   <= '0;
    end else begin
      if (relock_on) begin
        state_reg <= UNLOCKED;
        cnt_reg   <= '0;
      end else begin
        case (state_reg)
          UNLOCKED: begin
            state_reg <= RECENT_SHORT;
            cnt_reg   <= '0;
          end
          RECENT_SHORT: begin
            if (cnt_reg == SHORT_LAST) begin
              state_reg <= LONG_EN ? RECENT_LONG : LOCKED;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          RECENT_LONG: begin
            if (cnt_reg == LONG_LAST) begin
              state_reg <= LOCKED;
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
          default: begin
            state_reg <= LOCKED;
            cnt_reg   <= '0;
          end
        endcase
      end

      // A clear coinciding with an event leaves that one event counted.
      if (clr_events) begin
        evt_reg <= unlock_evt ? EVT_W'(1) : '0;
      end else if (unlock_evt && (evt_reg != EVT_MAX)) begin
        evt_reg <= evt_reg + 1'b1;
      end
    end
  end

  assign state   = state_reg;
  assign evt_cnt = evt_reg;

endmodule

// File: rtl/relock_status_mc.sv
// Multi-channel relock status monitor: per-channel FSMs plus registered status, counts and aggregates.
module relock_status_mc
  import relock_pkg::*;
#(
  parameter int              N_CH       = 4,
  parameter longint unsigned HOLD_SHORT = 64'd500_000_000,
  parameter longint unsigned HOLD_LONG  = 64'd6_000_000_000,
  parameter int              CNT_W      = 33,
  parameter int              EVT_W      = 16
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [N_CH-1:0]         relock_on,
  input  logic                    clr_events,
  output logic [2*N_CH-1:0]       status,
  output logic                    any_unlocked,
  output logic                    any_recent,
  output logic [N_CH*EVT_W-1:0]   event_cnt
);

  logic [2*N_CH-1:0]     status_next;
  logic [N_CH*EVT_W-1:0] event_next;
  logic [N_CH-1:0]       unlocked_flags;
  logic [N_CH-1:0]       recent_flags;

  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      relock_state_e    ch_state;
      logic [EVT_W-1:0] ch_evt;

      relock_status_ch #(
        .HOLD_SHORT (HOLD_SHORT),
        .HOLD_LONG  (HOLD_LONG),
        .CNT_W      (CNT_W),
        .EVT_W      (EVT_W)
      ) u_ch (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .relock_on  (relock_on[gi]),
        .clr_events (clr_events),
        .state      (ch_state),
        .evt_cnt    (ch_evt)
      );

      assign status_next[2*gi +: 2]        = ch_state;
      assign event_next[EVT_W*gi +: EVT_W] = ch_evt;
      assign unlocked_flags[gi]            = (ch_state == UNLOCKED);
      assign recent_flags[gi]              = (ch_state != LOCKED);
    end
  endgenerate

  // Output stage adds the second cycle of latency; reset values mirror the UNLOCKED reset state.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      status       <= {N_CH{UNLOCKED}};
      any_unlocked <= 1'b1;
      any_recent   <= 1'b1;
      event_cnt    <= '0;
    end else begin
      status       <= status_next;
      any_unlocked <= |unlocked_flags;
      any_recent   <= |recent_flags;
      event_cnt    <= event_next;
    end
  end

endmodule

// File: tb/tb_relock_status_mc.sv
// Directed bench for relock_status_mc: main build (HOLD_LONG=20) and a no-long-stage build.
module tb_relock_status_mc;

  logic       clk_in = 1'b0;
  logic       rst_in;
  logic [1:0] relock_on;
  logic       clr_events;

  logic [3:0] status_a;
  logic       any_unlocked_a;
  logic       any_recent_a;
  logic [5:0] event_cnt_a;

  logic [3:0] status_b;
  logic       any_unlocked_b;
  logic       any_recent_b;
  logic [5:0] event_cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  relock_status_mc #(
    .N_CH(2), .HOLD_SHORT(64'd10), .HOLD_LONG(64'd20), .CNT_W(6), .EVT_W(3)
  ) dut_a (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .relock_on    (relock_on),
    .clr_events   (clr_events),
    .status       (status_a),
    .any_unlocked (any_unlocked_a),
    .any_recent   (any_recent_a),
    .event_cnt    (event_cnt_a)
  );

  relock_status_mc #(
    .N_CH(2), .HOLD_SHORT(64'd10), .HOLD_LONG(64'd0), .CNT_W(6), .EVT_W(3)
  ) dut_b (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .relock_on    (relock_on),
    .clr_events   (clr_events),
    .status       (status_b),
    .any_unlocked (any_unlocked_b),
    .any_recent   (any_recent_b),
    .event_cnt    (event_cnt_b)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic expect_run(input string tag, input int n, input logic [3:0] exp);
    for (int k = 0; k < n; k++) begin
      tick();
      check_val(tag, status_a, exp);
    end
  endtask

  initial begin
    logic [1:0] exp_a;
    logic [1:0] exp_b;
    int         exp_evt;

    rst_in     = 1'b1;
    relock_on  = 2'b00;
    clr_events = 1'b0;
    repeat (3) @(posedge clk_in);
    #1;
    check_val("rst_status_a", status_a, 4'b0101);
    check_val("rst_status_b", status_b, 4'b0101);
    check_val("rst_any_unl", any_unlocked_a, 1'b1);
    check_val("rst_any_rec", any_recent_a, 1'b1);
    check_val("rst_evt", event_cnt_a, 6'd0);
    rst_in = 1'b0;

    // Clean relock after reset: 1 cycle of 01, 10 of 10, 20 of 11 (main) or straight to 00 (no-long).
    for (int i = 1; i <= 40; i++) begin
      tick();
      exp_a = (i == 1) ? 2'b01 : (i <= 11) ? 2'b10 : (i <= 31) ? 2'b11 : 2'b00;
      exp_b = (i == 1) ? 2'b01 : (i <= 11) ? 2'b10 : 2'b00;
      check_val("seq_status_a", status_a, {exp_a, exp_a});
      check_val("seq_status_b", status_b, {exp_b, exp_b});
      check_val("seq_evt_a", event_cnt_a, 6'd0);
      if (i == 1) begin
        check_val("seq_any_unl_1", any_unlocked_a, 1'b1);
        check_val("seq_any_rec_1", any_recent_a, 1'b1);
      end
      if (i == 5) begin
        check_val("seq_any_unl_5", any_unlocked_a, 1'b0);
        check_val("seq_any_rec_5", any_recent_a, 1'b1);
      end
      if (i == 35) begin
        check_val("seq_any_unl_35", any_unlocked_a, 1'b0);
        check_val("seq_any_rec_35", any_recent_a, 1'b0);
      end
    end

    // Ch0 unlock for 5 cycles from LOCKED; ch1 stays 00.
    relock_on = 2'b01;
    expect_run("unlk_lat", 1, 4'b0000);
    expect_run("unlk_on", 1, 4'b0001);
    check_val("unlk_evt", event_cnt_a, 6'b000_001);
    check_val("unlk_any_unl", any_unlocked_a, 1'b1);
    expect_run("unlk_hold", 3, 4'b0001);
    check_val("unlk_evt_hold", event_cnt_a, 6'b000_001);
    relock_on = 2'b00;
    expect_run("unlk_rel", 1, 4'b0001);
    expect_run("rs_a", 10, 4'b0010);
    expect_run("rl_a", 7, 4'b0011);

    // One-cycle pulse mid RECENT_LONG restarts the whole hold sequence.
    relock_on = 2'b01;
    expect_run("pulse_lat", 1, 4'b0011);
    relock_on = 2'b00;
    expect_run("pulse_out", 1, 4'b0001);
    check_val("pulse_evt", event_cnt_a, 6'b000_010);
    expect_run("rs_b", 10, 4'b0010);
    expect_run("rl_b", 20, 4'b0011);
    expect_run("lock_b", 1, 4'b0000);

    // Ch1 saturation at 7.
    for (int k = 1; k <= 9; k++) begin
      relock_on = 2'b10;
      tick();
      relock_on = 2'b00;
      tick();
      exp_evt = (k < 7) ? k : 7;
      check_val("sat_evt_ch1", event_cnt_a[5:3], exp_evt[2:0]);
      check_val("sat_evt_ch0", event_cnt_a[2:0], 3'd2);
      tick();
    end

    clr_events = 1'b1;
    tick();
    clr_events = 1'b0;
    tick();
    check_val("clr_evt", event_cnt_a, 6'd0);

    relock_on  = 2'b10;
    clr_events = 1'b1;
    tick();
    relock_on  = 2'b00;
    clr_events = 1'b0;
    tick();
    check_val("clr_with_evt", event_cnt_a, 6'b001_000);

    // Asynchronous reset between clock edges while ch1 is in RECENT_SHORT.
    repeat (3) tick();
    check_val("pre_arst_ch1", status_a[3:2], 2'b10);
    #3;
    rst_in = 1'b1;
    #1;
    check_val("arst_status_a", status_a, 4'b0101);
    check_val("arst_status_b", status_b, 4'b0101);
    check_val("arst_any_unl", any_unlocked_a, 1'b1);
    check_val("arst_any_rec", any_recent_a, 1'b1);
    check_val("arst_evt", event_cnt_a, 6'd0);
    tick();
    rst_in = 1'b0;
    tick();
    check_val("post_arst_s1", status_a, 4'b0101);
    check_val("post_arst_e1", event_cnt_a, 6'd0);
    tick();
    check_val("post_arst_s2", status_a, 4'b1010);
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("post_arst_evt", event_cnt_a, 6'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
